// File: rtl/ext_irq_controller.sv
// rtl/ext_irq_controller.sv - latches edge pulses into pending bits and arbitrates one masked request at a time
module ext_irq_controller #(
  parameter int NUM_LINES = 4,
  parameter int ID_W      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LINES-1:0] edge_pulse,
  input  logic                 mask_wr,
  input  logic [NUM_LINES-1:0] mask_din,
  input  logic                 ovf_clr,
  input  logic                 irq_ack,
  input  logic                 irq_done,
  output logic                 irq,
  output logic [ID_W-1:0]      irq_id,
  output logic [NUM_LINES-1:0] pending,
  output logic [NUM_LINES-1:0] mask,
  output logic [NUM_LINES-1:0] overrun
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t               state;
  logic                 ack_fire;
  logic [NUM_LINES-1:0] clr_vec;
  logic [NUM_LINES-1:0] req_vec;
  logic [NUM_LINES-1:0] ovr_set;
  logic [ID_W-1:0]      win_id;

  assign ack_fire = (state == REQ) && irq_ack;
  assign req_vec  = pending & mask;
  // A pulse landing on the ack cycle re-arms the line rather than counting as an overrun.
  assign ovr_set  = edge_pulse & pending & ~clr_vec;

  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      clr_vec[i] = ack_fire && (irq_id == ID_W'(i));
    end
  end

  always_comb begin
    win_id = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (req_vec[i]) win_id = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      overrun <= '0;
      mask    <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | edge_pulse;
      overrun <= (ovf_clr ? '0 : overrun) | ovr_set;
      if (mask_wr) mask <= mask_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      irq    <= 1'b0;
      irq_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_vec) begin
            state  <= REQ;
            irq    <= 1'b1;
            irq_id <= win_id;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state  <= SERVICE;
            irq    <= 1'b0;
            irq_id <= '0;
          end
        end
        SERVICE: begin
          if (irq_done) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          irq    <= 1'b0;
          irq_id <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_irq_controller.sv
// tb/tb_ext_irq_controller.sv - randomized and directed checks of ext_irq_controller against a behavioural model
module tb_ext_irq_controller;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] edge_pulse;
  logic         mask_wr;
  logic [N-1:0] mask_din;
  logic         ovf_clr;
  logic         irq_ack;
  logic         irq_done;
  logic         irq;
  logic [1:0]   irq_id;
  logic [N-1:0] pending;
  logic [N-1:0] mask;
  logic [N-1:0] overrun;

  int checks = 0;
  int passes = 0;

  ext_irq_controller #(.NUM_LINES(N), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .edge_pulse(edge_pulse), .mask_wr(mask_wr),
    .mask_din(mask_din), .ovf_clr(ovf_clr), .irq_ack(irq_ack), .irq_done(irq_done),
    .irq(irq), .irq_id(irq_id), .pending(pending), .mask(mask), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = waiting, 1 = request shown to core, 2 = ISR running.
  int m_phase;
  int m_line;
  int m_pend;
  int m_mask;
  int m_ovr;

  always @(posedge clk or negedge rst_n) begin : model
    int clr;
    int enabled;
    int nxt_line;
    if (!rst_n) begin
      m_phase <= 0; m_line <= 0; m_pend <= 0; m_mask <= 0; m_ovr <= 0;
    end else begin
      clr = (m_phase == 1 && irq_ack) ? (1 << m_line) : 0;
      enabled = m_pend & m_mask;
      nxt_line = -1;
      for (int i = N - 1; i >= 0; i--) if ((enabled >> i) & 1) nxt_line = i;
      if (m_phase == 0 && nxt_line >= 0) begin
        m_phase <= 1; m_line <= nxt_line;
      end else if (m_phase == 1 && irq_ack) begin
        m_phase <= 2;
      end else if (m_phase == 2 && irq_done) begin
        m_phase <= 0;
      end
      m_ovr  <= (ovf_clr ? 0 : m_ovr) | (int'(edge_pulse) & m_pend & ~clr);
      m_pend <= (m_pend & ~clr) | int'(edge_pulse);
      if (mask_wr) m_mask <= int'(mask_din);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    #1;
    chk("irq", int'(irq), (m_phase == 1) ? 1 : 0);
    chk("irq_id", int'(irq_id), (m_phase == 1) ? m_line : 0);
    chk("pending", int'(pending), m_pend);
    chk("mask", int'(mask), m_mask);
    chk("overrun", int'(overrun), m_ovr);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    edge_pulse = '0; mask_wr = 0; mask_din = '0; ovf_clr = 0; irq_ack = 0; irq_done = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    step();
    rst_n = 1;
    step();
  endtask

  task automatic set_mask(input logic [N-1:0] m);
    mask_wr = 1; mask_din = m;
    step();
    mask_wr = 0; mask_din = '0;
  endtask

  task automatic pulse(input logic [N-1:0] p);
    edge_pulse = p;
    step();
    edge_pulse = '0;
  endtask

  task automatic ack();
    irq_ack = 1; step(); irq_ack = 0;
  endtask

  task automatic done();
    irq_done = 1; step(); irq_done = 0;
  endtask

  initial begin
    // 1: reset with every input active
    rst_n = 0;
    edge_pulse = '1; mask_wr = 1; mask_din = '1; ovf_clr = 1; irq_ack = 1; irq_done = 1;
    #3;
    chk("t1 rst irq", int'(irq), 0);
    chk("t1 rst all", int'({irq_id, pending, mask, overrun}), 0);
    step(); step();
    chk("t1 rst held", int'({irq, irq_id, pending, mask, overrun}), 0);
    idle_inputs();
    rst_n = 1;
    step();
    pulse(4'b0100);
    chk("t1 pending", int'(pending), 4'b0100);
    step();
    chk("t1 masked irq", int'(irq), 0);

    // 2: earliest request timing, ack, done
    do_reset();
    set_mask(4'b1111);
    pulse(4'b0010);
    chk("t2 pend N", int'(pending), 4'b0010);
    chk("t2 irq N", int'(irq), 0);
    step();
    chk("t2 irq N+1", int'(irq), 1);
    chk("t2 id N+1", int'(irq_id), 1);
    ack();
    chk("t2 ack pend", int'(pending), 0);
    chk("t2 ack irq", int'(irq), 0);
    done();
    step();
    chk("t2 idle irq", int'(irq), 0);

    // 3: priority and back-to-back
    pulse(4'b1001);
    step();
    chk("t3 first id", int'(irq_id), 0);
    chk("t3 first irq", int'(irq), 1);
    ack();
    done();
    chk("t3 gap irq", int'(irq), 0);
    step();
    chk("t3 second irq", int'(irq), 1);
    chk("t3 second id", int'(irq_id), 3);
    ack();
    done();

    // 4: overrun, coincident ack+pulse, clear
    pulse(4'b0100);
    pulse(4'b0100);
    chk("t4 overrun", int'(overrun), 4'b0100);
    chk("t4 id", int'(irq_id), 2);
    ovf_clr = 1; step(); ovf_clr = 0;
    chk("t4 ovf_clr", int'(overrun), 0);
    edge_pulse = 4'b0100; irq_ack = 1;
    step();
    edge_pulse = '0; irq_ack = 0;
    chk("t4 set wins", int'(pending), 4'b0100);
    chk("t4 no ovr", int'(overrun), 0);
    done();
    step();
    pulse(4'b0100);
    ovf_clr = 1; edge_pulse = 4'b0100; step(); ovf_clr = 0; edge_pulse = '0;
    chk("t4 ovr set wins", int'(overrun), 4'b0100);
    ack(); done();
    ovf_clr = 1; step(); ovf_clr = 0;

    // 5: masking after selection does not disturb the request
    pulse(4'b0010);
    step();
    chk("t5 id", int'(irq_id), 1);
    set_mask(4'b0000);
    chk("t5 hold irq", int'(irq), 1);
    chk("t5 hold id", int'(irq_id), 1);
    pulse(4'b1001);
    chk("t5 still id", int'(irq_id), 1);
    ack(); done();
    step(); step();
    chk("t5 masked idle", int'(irq), 0);
    chk("t5 pend kept", int'(pending), 4'b1001);

    // 6: asynchronous reset in REQ and in SERVICE
    do_reset();
    set_mask(4'b1111);
    pulse(4'b1000);
    step();
    chk("t6 in req", int'(irq), 1);
    #2 rst_n = 0;
    #1;
    chk("t6 req rst irq", int'(irq), 0);
    chk("t6 req rst pend", int'(pending), 0);
    step();
    rst_n = 1;
    step();
    set_mask(4'b1111);
    pulse(4'b0001);
    step();
    ack();
    #2 rst_n = 0;
    #1;
    chk("t6 svc rst irq", int'(irq), 0);
    chk("t6 svc rst mask", int'(mask), 0);
    step();
    rst_n = 1;
    step();
    set_mask(4'b0110);
    pulse(4'b0100);
    step();
    chk("t6 resume irq", int'(irq), 1);
    chk("t6 resume id", int'(irq_id), 2);
    ack(); done();

    // Randomized traffic checked every cycle by the compare process
    for (int c = 0; c < 3000; c++) begin
      edge_pulse = '0;
      for (int b = 0; b < N; b++) edge_pulse[b] = ($urandom_range(0, 5) == 0);
      mask_wr  = ($urandom_range(0, 15) == 0);
      mask_din = N'($urandom);
      ovf_clr  = ($urandom_range(0, 19) == 0);
      irq_ack  = ($urandom_range(0, 2) == 0);
      irq_done = ($urandom_range(0, 2) == 0);
      rst_n    = ($urandom_range(0, 199) != 0);
      step();
    end
    idle_inputs();
    rst_n = 1;
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
